// File: rtl/pll_phase_pkg.sv
// Shared types and constants for the PLL dynamic phase-shift sequencer.
package pll_phase_pkg;

    localparam int POS_W = 10;

    typedef logic [POS_W-1:0] pos_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STEP_HI = 3'd2;
    localparam logic [2:0] ST_STEP_LO = 3'd3;
    localparam logic [2:0] ST_LOAD    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        SETUP   = ST_SETUP,
        STEP_HI = ST_STEP_HI,
        STEP_LO = ST_STEP_LO,
        LOAD    = ST_LOAD,
        DONE    = ST_DONE
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_phase_stepper_if.sv
// Command channel into the phase stepper.
// A command transfers on a rising clock edge where cmd_valid and cmd_ready are both high;
// the source must hold cmd_valid and the payload stable until that edge.
interface pll_phase_stepper_if #(
    parameter int CNT_W = 8
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_sel;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_load;

    modport master (
        output cmd_valid,
        output cmd_sel,
        output cmd_dir,
        output cmd_steps,
        output cmd_load,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_sel,
        input  cmd_dir,
        input  cmd_steps,
        input  cmd_load,
        output cmd_ready
    );

endinterface

// File: rtl/pll_phase_stepper.sv
// Turns step/load commands into timed phasestep/phaseloadreg strobes for the ECP5 PLL
// dynamic phase port and tracks the accumulated phase of each PLL output.
module pll_phase_stepper
    import pll_phase_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int STEP_W    = 4,
    parameter int STEP_GAP  = 4,
    parameter int CNT_W     = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_n,
    pll_phase_stepper_if.slave    cmd,
    input  logic                  locked,
    output logic [1:0]            phasesel,
    output logic                  phasedir,
    output logic                  phasestep,
    output logic                  phaseloadreg,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [4*POS_W-1:0]    pos_o,
    output state_e                state_o
);

    if (SETUP_CYC < 1 || STEP_W < 1 || STEP_GAP < 1) begin : g_bad_param
        $error("pll_phase_stepper: SETUP_CYC, STEP_W and STEP_GAP must all be >= 1");
    end

    localparam int MAX_CYC = max3(SETUP_CYC, STEP_W, STEP_GAP);
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] HI_LD    = TW'(STEP_W - 1);
    localparam logic [TW-1:0] LO_LD    = TW'(STEP_GAP - 1);

    logic [2:0]       state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             load_q, load_d;
    logic [1:0]       phasesel_q, phasesel_d;
    logic             phasedir_q, phasedir_d;
    logic             phasestep_q, phasestep_d;
    logic             phaseloadreg_q, phaseloadreg_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    pos_t [3:0]       pos_q, pos_d;

    logic accept;
    logic running;
    logic abort;

    assign cmd.cmd_ready = (state_q == ST_IDLE) && locked;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign running       = (state_q == ST_SETUP) || (state_q == ST_STEP_HI) ||
                           (state_q == ST_STEP_LO) || (state_q == ST_LOAD);
    assign abort         = running && !locked;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        load_d     = load_q;
        phasesel_d = phasesel_q;
        phasedir_d = phasedir_q;
        err_d      = err_q;
        pos_d      = pos_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_SETUP;
                    phasesel_d = cmd.cmd_sel;
                    phasedir_d = cmd.cmd_dir;
                    rem_d      = cmd.cmd_steps;
                    load_d     = cmd.cmd_load;
                    err_d      = 1'b0;
                end
            end
            ST_SETUP: begin
                if (tmr_q == '0) begin
                    if (load_q)             state_d = ST_LOAD;
                    else if (rem_q == '0)   state_d = ST_DONE;
                    else                    state_d = ST_STEP_HI;
                end
            end
            ST_STEP_HI: begin
                if (tmr_q == '0) begin
                    state_d = ST_STEP_LO;
                    rem_d   = rem_q - CNT_W'(1);
                    pos_d[phasesel_q] = phasedir_q ? pos_q[phasesel_q] - pos_t'(1)
                                                   : pos_q[phasesel_q] + pos_t'(1);
                end
            end
            ST_STEP_LO: begin
                if (tmr_q == '0) state_d = (rem_q != '0) ? ST_STEP_HI : ST_DONE;
            end
            ST_LOAD: begin
                if (tmr_q == '0) begin
                    state_d           = ST_DONE;
                    pos_d[phasesel_q] = '0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Lock loss wins over any step completing on the same edge.
        if (abort) begin
            state_d = ST_DONE;
            rem_d   = rem_q;
            pos_d   = pos_q;
            err_d   = 1'b1;
        end

        // One timer serves every timed state; it reloads on each state change.
        tmr_d = tmr_q;
        if (state_d != state_q) begin
            case (state_d)
                ST_SETUP:   tmr_d = SETUP_LD;
                ST_STEP_HI: tmr_d = HI_LD;
                ST_STEP_LO: tmr_d = LO_LD;
                ST_LOAD:    tmr_d = HI_LD;
                default:    tmr_d = '0;
            endcase
        end else if (tmr_q != '0) begin
            tmr_d = tmr_q - TW'(1);
        end

        phasestep_d    = (state_d == ST_STEP_HI);
        phaseloadreg_d = (state_d == ST_LOAD);
        done_d         = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            tmr_q          <= '0;
            rem_q          <= '0;
            load_q         <= 1'b0;
            phasesel_q     <= 2'd0;
            phasedir_q     <= 1'b0;
            phasestep_q    <= 1'b0;
            phaseloadreg_q <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            pos_q          <= '0;
        end else begin
            state_q        <= state_d;
            tmr_q          <= tmr_d;
            rem_q          <= rem_d;
            load_q         <= load_d;
            phasesel_q     <= phasesel_d;
            phasedir_q     <= phasedir_d;
            phasestep_q    <= phasestep_d;
            phaseloadreg_q <= phaseloadreg_d;
            done_q         <= done_d;
            err_q          <= err_d;
            pos_q          <= pos_d;
        end
    end

    assign phasesel     = phasesel_q;
    assign phasedir     = phasedir_q;
    assign phasestep    = phasestep_q;
    assign phaseloadreg = phaseloadreg_q;
    assign done         = done_q;
    assign err          = err_q;
    assign busy         = (state_q != ST_IDLE);
    assign pos_o        = pos_q;
    assign state_o      = state_e'(state_q);

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Directed bench for pll_phase_stepper: timeline model of each command plus literal timing checks.
module tb_pll_phase_stepper;
    import pll_phase_pkg::*;

    localparam int S     = 2;
    localparam int W     = 4;
    localparam int G     = 4;
    localparam int CNT_W = 8;

    // ---------------- clock / reset ----------------
    logic clk_i   = 1'b0;
    logic reset_n = 1'b0;
    logic locked  = 1'b1;

    always #5 clk_i = ~clk_i;

    logic [1:0]  phasesel;
    logic        phasedir, phasestep, phaseloadreg, busy, done, err;
    logic [39:0] pos_o;
    state_e      state_o;

    pll_phase_stepper_if #(.CNT_W(CNT_W)) cmd_if ();

    pll_phase_stepper #(
        .SETUP_CYC(S), .STEP_W(W), .STEP_GAP(G), .CNT_W(CNT_W)
    ) dut (
        .clk_i        (clk_i),
        .reset_n      (reset_n),
        .cmd          (cmd_if.slave),
        .locked       (locked),
        .phasesel     (phasesel),
        .phasedir     (phasedir),
        .phasestep    (phasestep),
        .phaseloadreg (phaseloadreg),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .pos_o        (pos_o),
        .state_o      (state_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each command is a timeline indexed by t = cycles since the accepting edge.
    bit         m_armed  = 0;
    bit         m_active = 0;
    bit         m_abort  = 0;
    bit         m_err    = 0;
    bit         m_load   = 0;
    logic       m_dir    = 1'b0;
    logic [1:0] m_sel    = 2'd0;
    int         m_steps  = 0;
    int         m_t      = 0;
    int         m_done_t = 0;
    logic [9:0] m_base   = '0;
    logic [9:0] m_frozen = '0;
    logic [9:0] m_pos [4] = '{default: '0};

    function automatic logic [9:0] cur_pos(input int t);
        int n;
        if (m_load) return (t >= S + W) ? 10'd0 : m_base;
        if (t < S + W) n = 0;
        else           n = (t - S - W) / (W + G) + 1;
        if (n > m_steps) n = m_steps;
        return m_dir ? m_base - 10'(n) : m_base + 10'(n);
    endfunction

    always @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            m_armed  = 1;
            m_active = 0;
            m_abort  = 0;
            m_err    = 0;
            m_sel    = 2'd0;
            m_dir    = 1'b0;
            for (int i = 0; i < 4; i++) m_pos[i] = '0;
        end else if (m_active) begin
            if (!m_abort && m_t < m_done_t && !locked) begin
                m_abort  = 1;
                m_frozen = cur_pos(m_t);
                m_done_t = m_t + 1;
                m_err    = 1;
            end
            if (m_t == m_done_t) begin
                m_active     = 0;
                m_pos[m_sel] = m_abort ? m_frozen : cur_pos(m_t);
            end else begin
                m_t++;
            end
        end else if (cmd_if.cmd_valid && locked) begin
            m_active = 1;
            m_abort  = 0;
            m_err    = 0;
            m_t      = 0;
            m_sel    = cmd_if.cmd_sel;
            m_dir    = cmd_if.cmd_dir;
            m_load   = cmd_if.cmd_load;
            m_steps  = int'(cmd_if.cmd_steps);
            m_base   = m_pos[cmd_if.cmd_sel];
            m_done_t = m_load ? S + W : S + m_steps * (W + G);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_i) begin
        logic [9:0] p [4];
        logic       e_step, e_load, e_done;
        int         u;
        if (reset_n && m_armed) begin
            p = m_pos;
            u = m_t - S;
            e_step = 0;
            e_load = 0;
            e_done = 0;
            if (m_active) begin
                p[m_sel] = m_abort ? m_frozen : cur_pos(m_t);
                e_done   = (m_t == m_done_t);
                if (!m_abort) begin
                    e_step = !m_load && m_t >= S && m_t < m_done_t && (u % (W + G)) < W;
                    e_load = m_load && m_t >= S && m_t < S + W;
                end
            end
            chk("cyc_phasestep",    phasestep,        e_step);
            chk("cyc_phaseloadreg", phaseloadreg,     e_load);
            chk("cyc_done",         done,             e_done);
            chk("cyc_err",          err,              m_err);
            chk("cyc_busy",         busy,             m_active);
            chk("cyc_ready",        cmd_if.cmd_ready, !m_active && locked);
            chk("cyc_phasesel",     phasesel,         m_sel);
            chk("cyc_phasedir",     phasedir,         m_dir);
            chk("cyc_pos",          pos_o,            {p[3], p[2], p[1], p[0]});
        end
    end

    // ---------------- driver tasks ----------------
    logic [39:0] snap [64];
    logic [63:0] step_mask;
    logic [63:0] load_mask;

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Entered at the start of a cycle; returns at the start of cycle 0 of the accepted command.
    task automatic send(input logic [1:0] sel, input logic dir, input logic [7:0] steps,
                        input logic load, input bit keep, output int waited);
        cmd_if.cmd_sel   = sel;
        cmd_if.cmd_dir   = dir;
        cmd_if.cmd_steps = steps;
        cmd_if.cmd_load  = load;
        cmd_if.cmd_valid = 1'b1;
        waited = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_i);
            if (cmd_if.cmd_ready) begin
                waited = n;
                next_cycle();
                if (!keep) cmd_if.cmd_valid = 1'b0;
                break;
            end
            next_cycle();
        end
        checks++;
        if (waited < 0) begin
            errors++;
            $display("FAIL accept_timeout: got no accept within 100 cycles, required an accept");
            cmd_if.cmd_valid = 1'b0;
        end
    endtask

    // Records strobes and positions per cycle; returns on the negedge of the done cycle.
    task automatic watch(input int drop_at, input bit hold, input logic [1:0] b_sel,
                         input logic b_dir, input logic [7:0] b_steps, output int done_cyc);
        done_cyc  = -1;
        step_mask = '0;
        load_mask = '0;
        for (int k = 0; k < 200; k++) begin
            if (k == drop_at) locked = 1'b0;
            if (hold) begin
                if (k < 6) begin
                    cmd_if.cmd_sel   = 2'($urandom_range(0, 3));
                    cmd_if.cmd_dir   = 1'($urandom_range(0, 1));
                    cmd_if.cmd_steps = 8'($urandom_range(0, 255));
                    cmd_if.cmd_load  = 1'($urandom_range(0, 1));
                end else begin
                    cmd_if.cmd_sel   = b_sel;
                    cmd_if.cmd_dir   = b_dir;
                    cmd_if.cmd_steps = b_steps;
                    cmd_if.cmd_load  = 1'b0;
                end
            end
            @(negedge clk_i);
            if (k < 64) begin
                step_mask[k] = phasestep;
                load_mask[k] = phaseloadreg;
                snap[k]      = pos_o;
            end
            if (done) begin
                done_cyc = k;
                break;
            end
            next_cycle();
        end
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL done_timeout: got no done within 200 cycles, required a done pulse");
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w;
        int dc;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_sel   = 2'd0;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_steps = '0;
        cmd_if.cmd_load  = 1'b0;
        reset_n = 1'b0;
        locked  = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 reset_n = 1'b1;
        @(negedge clk_i);
        chk("rst_phasestep",    phasestep,        1'b0);
        chk("rst_phaseloadreg", phaseloadreg,     1'b0);
        chk("rst_pos",          pos_o,            40'd0);
        chk("rst_ready",        cmd_if.cmd_ready, 1'b1);
        next_cycle();

        // sel=2, increment by 2
        send(2'd2, 1'b0, 8'd2, 1'b0, 0, w);
        watch(-1, 0, 2'd0, 1'b0, 8'd0, dc);
        chk("inc2_done_cycle", dc, 18);
        chk("inc2_step_mask", step_mask[31:0], 32'h0000_3C3C);
        chk("inc2_pos2_c5",  snap[5][29:20],  10'd0);
        chk("inc2_pos2_c6",  snap[6][29:20],  10'd1);
        chk("inc2_pos2_c13", snap[13][29:20], 10'd1);
        chk("inc2_pos2_c14", snap[14][29:20], 10'd2);
        next_cycle();
        @(negedge clk_i);
        chk("inc2_ready_c19", cmd_if.cmd_ready, 1'b1);
        next_cycle();

        // pos1 wraps below zero and back
        send(2'd1, 1'b1, 8'd3, 1'b0, 0, w);
        watch(-1, 0, 2'd0, 1'b0, 8'd0, dc);
        chk("dec3_done_cycle", dc, 26);
        chk("dec3_pos1", snap[26][19:10], 10'd1021);
        next_cycle();
        send(2'd1, 1'b0, 8'd3, 1'b0, 0, w);
        watch(-1, 0, 2'd0, 1'b0, 8'd0, dc);
        chk("inc3_pos1", snap[26][19:10], 10'd0);
        chk("inc3_pos2_kept", snap[26][29:20], 10'd2);
        next_cycle();

        // zero steps: no strobe
        send(2'd0, 1'b0, 8'd0, 1'b0, 0, w);
        watch(-1, 0, 2'd0, 1'b0, 8'd0, dc);
        chk("zero_done_cycle", dc, 2);
        chk("zero_step_mask", step_mask[31:0], 32'h0);
        next_cycle();

        // shift output 3, then reload its static phase (steps field ignored)
        send(2'd3, 1'b0, 8'd1, 1'b0, 0, w);
        watch(-1, 0, 2'd0, 1'b0, 8'd0, dc);
        chk("sel3_pos3", snap[10][39:30], 10'd1);
        next_cycle();
        send(2'd3, 1'b0, 8'd5, 1'b1, 0, w);
        watch(-1, 0, 2'd0, 1'b0, 8'd0, dc);
        chk("load_done_cycle", dc, 6);
        chk("load_mask", load_mask[31:0], 32'h0000_003C);
        chk("load_no_step", step_mask[31:0], 32'h0);
        chk("load_pos3_c5", snap[5][39:30], 10'd1);
        chk("load_pos3_c6", snap[6][39:30], 10'd0);
        next_cycle();

        // lock lost during the second of four steps
        send(2'd0, 1'b0, 8'd4, 1'b0, 0, w);
        watch(11, 0, 2'd0, 1'b0, 8'd0, dc);
        chk("abort_done_cycle", dc, 12);
        chk("abort_step_mask", step_mask[31:0], 32'h0000_0C3C);
        chk("abort_pos0", snap[12][9:0], 10'd1);
        chk("abort_err", err, 1'b1);
        next_cycle();
        @(negedge clk_i);
        chk("abort_ready_unlocked", cmd_if.cmd_ready, 1'b0);
        next_cycle();
        locked = 1'b1;
        send(2'd0, 1'b0, 8'd0, 1'b0, 0, w);
        watch(-1, 0, 2'd0, 1'b0, 8'd0, dc);
        chk("relock_err_cleared", err, 1'b0);
        next_cycle();

        // payload churns while busy; held command follows after exactly one idle cycle
        send(2'd3, 1'b1, 8'd1, 1'b0, 1, w);
        watch(-1, 1, 2'd2, 1'b1, 8'd1, dc);
        chk("hold_a_done_cycle", dc, 10);
        chk("hold_a_pos3", snap[10][39:30], 10'd1023);
        next_cycle();
        send(2'd2, 1'b1, 8'd1, 1'b0, 0, w);
        chk("hold_b_wait", w, 0);
        watch(-1, 0, 2'd0, 1'b0, 8'd0, dc);
        chk("hold_b_done_cycle", dc, 10);
        chk("hold_b_pos2", snap[10][29:20], 10'd1);
        next_cycle();

        // asynchronous reset during STEP_HI
        send(2'd1, 1'b0, 8'd3, 1'b0, 0, w);
        repeat (3) next_cycle();
        @(negedge clk_i);
        chk("pre_reset_step", phasestep, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_reset_step", phasestep, 1'b0);
        chk("async_reset_pos",  pos_o,     40'd0);
        chk("async_reset_busy", busy,      1'b0);
        @(posedge clk_i);
        #1 reset_n = 1'b1;
        repeat (3) next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
